pwm_fader: RTL and testbench

PWM_FADER -- requirements
Module: pwm_fader

---
 rtl/pwm_fader_pkg.sv | 22 ++
 rtl/pwm_fader_chan.sv | 83 ++++++++
 rtl/pwm_fader.sv | 97 +++++++++
 tb/tb_pwm_fader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_fader_pkg.sv
// pwm_fader_pkg
//   Shared definitions for the LED PWM fader: parameter defaults, the legal
//   range of each parameter, and the helper that sizes the channel-index port.
package pwm_fader_pkg;

  localparam int NCH_DEFAULT      = 4;
  localparam int PW_DEFAULT       = 8;
  localparam int FADE_DIV_DEFAULT = 4096;

  localparam int NCH_MIN      = 1;
  localparam int NCH_MAX      = 16;
  localparam int PW_MIN       = 4;
  localparam int PW_MAX       = 16;
  localparam int FADE_DIV_MIN = 2;

  // Channel-index width: clog2(nch), but never narrower than one bit so a
  // single-channel build still has a real port.
  function automatic int chan_width(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/pwm_fader_chan.sv
// pwm_fader_chan
//   One LED channel: holds target/current/duty levels, steps the current level
//   toward the target on fade ticks, and compares duty against the shared PWM
//   counter to produce a registered LED drive.
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_wr_en           accepted write addressed to this channel
//   i_wr_level        new target level
//   i_wr_instant      1 = current level jumps to the target as well
//   i_tick            single-cycle fade step strobe
//   i_period_end      high while the shared PWM counter is at its last value
//   i_pwm_cnt         shared PWM counter
//   o_led             registered PWM output
//   o_busy            current level differs from target
module pwm_fader_chan
  import pwm_fader_pkg::*;
#(
  parameter int PW = PW_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_wr_en,
  input  logic [PW-1:0] i_wr_level,
  input  logic          i_wr_instant,
  input  logic          i_tick,
  input  logic          i_period_end,
  input  logic [PW-1:0] i_pwm_cnt,
  output logic          o_led,
  output logic          o_busy
);

  logic [PW-1:0] target_reg, target_next;
  logic [PW-1:0] cur_reg, cur_next;
  logic [PW-1:0] duty_reg, duty_next;
  logic          led_reg, led_next;

  always_comb begin
    target_next = target_reg;
    cur_next    = cur_reg;
    duty_next   = duty_reg;

    // A write in the same cycle as a tick takes priority; the channel simply
    // misses that step rather than stepping from a stale level.
    if (i_wr_en) begin
      target_next = i_wr_level;
      if (i_wr_instant) begin
        cur_next = i_wr_level;
      end
    end else if (i_tick && (cur_reg != target_reg)) begin
      if (cur_reg < target_reg) begin
        cur_next = cur_reg + PW'(1);
      end else begin
        cur_next = cur_reg - PW'(1);
      end
    end

    // Duty only reloads on the last count of a period, so a level change can
    // never shorten or stretch a pulse already in progress.
    if (i_period_end) begin
      duty_next = cur_reg;
    end

    led_next = (i_pwm_cnt < duty_reg);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      target_reg <= '0;
      cur_reg    <= '0;
      duty_reg   <= '0;
      led_reg    <= 1'b0;
    end else begin
      target_reg <= target_next;
      cur_reg    <= cur_next;
      duty_reg   <= duty_next;
      led_reg    <= led_next;
    end
  end

  assign o_led  = led_reg;
  assign o_busy = (cur_reg != target_reg);

endmodule

// File: rtl/pwm_fader.sv
// pwm_fader
//   Multi-channel LED fader. Owns the shared PWM counter, the fade-tick
//   prescaler and the write decode; each channel is a pwm_fader_chan.
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_wr_valid        write request
//   o_wr_ready        write accept (high whenever out of reset)
//   i_wr_chan         target channel; indices >= NCH are ignored
//   i_wr_level        target brightness
//   i_wr_instant      1 = jump immediately, 0 = fade one step per tick
//   o_led[NCH]        per-channel PWM output
//   o_busy[NCH]       per-channel fade-in-progress flag
module pwm_fader
  import pwm_fader_pkg::*;
#(
  parameter int NCH      = NCH_DEFAULT,
  parameter int PW       = PW_DEFAULT,
  parameter int FADE_DIV = FADE_DIV_DEFAULT
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_wr_valid,
  output logic                       o_wr_ready,
  input  logic [chan_width(NCH)-1:0] i_wr_chan,
  input  logic [PW-1:0]              i_wr_level,
  input  logic                       i_wr_instant,
  output logic [NCH-1:0]             o_led,
  output logic [NCH-1:0]             o_busy
);

  localparam int            DW       = $clog2(FADE_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(FADE_DIV - 1);
  localparam logic [PW-1:0] PWM_LAST = '1;

  if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
    $fatal(1, "pwm_fader: NCH=%0d outside %0d..%0d", NCH, NCH_MIN, NCH_MAX);
  end
  if (PW < PW_MIN || PW > PW_MAX) begin : g_bad_pw
    $fatal(1, "pwm_fader: PW=%0d outside %0d..%0d", PW, PW_MIN, PW_MAX);
  end
  if (FADE_DIV < FADE_DIV_MIN) begin : g_bad_div
    $fatal(1, "pwm_fader: FADE_DIV=%0d below %0d", FADE_DIV, FADE_DIV_MIN);
  end

  logic [PW-1:0] pwm_cnt_reg, pwm_cnt_next;
  logic [DW-1:0] presc_reg, presc_next;
  logic          tick;
  logic          period_end;
  logic          wr_accept;
  logic          wr_in_range;
  logic [NCH-1:0] wr_en;

  assign tick       = (presc_reg == DIV_LAST);
  assign period_end = (pwm_cnt_reg == PWM_LAST);

  always_comb begin
    pwm_cnt_next = pwm_cnt_reg + PW'(1);
    presc_next   = tick ? '0 : presc_reg + DW'(1);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pwm_cnt_reg <= '0;
      presc_reg   <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_next;
      presc_reg   <= presc_next;
    end
  end

  // Ready tracks reset directly so it drops the instant reset asserts.
  assign o_wr_ready  = i_reset_n;
  assign wr_accept   = i_wr_valid & o_wr_ready;
  // When NCH is not a power of two the index port can name channels that do
  // not exist; those writes fall through with no effect.
  assign wr_in_range = (int'(i_wr_chan) < NCH);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign wr_en[gi] = wr_accept && wr_in_range && (int'(i_wr_chan) == gi);

    pwm_fader_chan #(
      .PW (PW)
    ) u_chan (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_wr_en      (wr_en[gi]),
      .i_wr_level   (i_wr_level),
      .i_wr_instant (i_wr_instant),
      .i_tick       (tick),
      .i_period_end (period_end),
      .i_pwm_cnt    (pwm_cnt_reg),
      .o_led        (o_led[gi]),
      .o_busy       (o_busy[gi])
    );
  end

endmodule

// File: tb/tb_pwm_fader.sv
module tb_pwm_fader;

  localparam int NCH      = 4;
  localparam int PW       = 8;
  localparam int FADE_DIV = 16;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_valid3;
  logic [1:0] wr_chan;
  logic [7:0] wr_level;
  logic       wr_instant;

  logic       wr_ready;
  logic [3:0] led;
  logic [3:0] busy;
  logic       wr_ready3;
  logic [2:0] led3;
  logic [2:0] busy3;

  pwm_fader #(.NCH(NCH), .PW(PW), .FADE_DIV(FADE_DIV)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_wr_valid   (wr_valid),
    .o_wr_ready   (wr_ready),
    .i_wr_chan    (wr_chan),
    .i_wr_level   (wr_level),
    .i_wr_instant (wr_instant),
    .o_led        (led),
    .o_busy       (busy)
  );

  // Three-channel copy: its 2-bit index port can address a channel 3 that
  // does not exist, which is how out-of-range writes are exercised.
  pwm_fader #(.NCH(3), .PW(PW), .FADE_DIV(FADE_DIV)) dut3 (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_wr_valid   (wr_valid3),
    .o_wr_ready   (wr_ready3),
    .i_wr_chan    (wr_chan),
    .i_wr_level   (wr_level),
    .i_wr_instant (wr_instant),
    .o_led        (led3),
    .o_busy       (busy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: prescaler phase and channel-2 level of the main DUT.
  int presc_m;
  int cur2_m;
  int tgt2_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_m <= 0;
      cur2_m  <= 0;
      tgt2_m  <= 0;
    end else begin
      presc_m <= (presc_m == FADE_DIV - 1) ? 0 : presc_m + 1;
      if (wr_valid && wr_chan == 2'd2) begin
        tgt2_m <= int'(wr_level);
        if (wr_instant) cur2_m <= int'(wr_level);
      end else if (presc_m == FADE_DIV - 1 && cur2_m != tgt2_m) begin
        cur2_m <= (cur2_m < tgt2_m) ? cur2_m + 1 : cur2_m - 1;
      end
    end
  end

  // Scoreboard
  typedef struct {
    string tag;
    int    exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks;
  int  errors;

  task automatic expect_val(input string tag, input int exp);
    sb_t item;
    item.tag = tag;
    item.exp = exp;
    sb_q.push_back(item);
  endtask

  task automatic check_next(input int obs);
    sb_t item;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %0d expected none", obs);
    end else begin
      item = sb_q.pop_front();
      assert (obs === item.exp) else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d", item.tag, obs, item.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [7:0] lvl,
                          input logic inst, input logic to3);
    wr_chan    = ch;
    wr_level   = lvl;
    wr_instant = inst;
    if (to3) wr_valid3 = 1'b1;
    else     wr_valid  = 1'b1;
    step();
    wr_valid  = 1'b0;
    wr_valid3 = 1'b0;
  endtask

  // Let duty settle, then count LED high cycles over one full period while
  // also counting busy cycles over the whole window.
  task automatic measure(input int idx, output int hi, output int bsy);
    hi  = 0;
    bsy = 0;
    for (int i = 0; i < 300 + 256; i++) begin
      if (busy[idx]) bsy++;
      if (i >= 300 && led[idx]) hi++;
      step();
    end
  endtask

  task automatic wait_tick_cycle(output int found);
    found = 0;
    for (int i = 0; i < 2 * FADE_DIV; i++) begin
      if (presc_m == FADE_DIV - 1) begin
        found = 1;
        break;
      end
      step();
    end
  endtask

  task automatic idle_check(input string pfx);
    int nz_led;
    int nz_busy;
    int not_ready;
    nz_led = 0; nz_busy = 0; not_ready = 0;
    expect_val({pfx, "_led_nonzero_cycles"}, 0);
    expect_val({pfx, "_busy_nonzero_cycles"}, 0);
    expect_val({pfx, "_ready_low_cycles"}, 0);
    for (int i = 0; i < 1000; i++) begin
      if (led != 4'b0000) nz_led++;
      if (busy != 4'b0000) nz_busy++;
      if (wr_ready !== 1'b1) not_ready++;
      step();
    end
    check_next(nz_led);
    check_next(nz_busy);
    check_next(not_ready);
    $display("idle %s: led_nz=%0d busy_nz=%0d ready_low=%0d", pfx, nz_led, nz_busy, not_ready);
  endtask

  initial begin
    int hi;
    int bsy;
    int dur;
    int found;
    int nz_led3;
    int nz_busy3;

    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    wr_valid   = 1'b0;
    wr_valid3  = 1'b0;
    wr_chan    = 2'd0;
    wr_level   = 8'd0;
    wr_instant = 1'b0;

    // Reset state
    repeat (3) step();
    expect_val("reset_led", 0);
    expect_val("reset_busy", 0);
    expect_val("reset_ready", 0);
    check_next(int'(led));
    check_next(int'(busy));
    check_next(int'(wr_ready));
    $display("reset: led=%b busy=%b ready=%b", led, busy, wr_ready);

    rst_n = 1'b1;
    idle_check("idle1");

    // Instant write, mid scale
    do_write(2'd1, 8'd64, 1'b1, 1'b0);
    expect_val("ch1_inst64_high", 64);
    expect_val("ch1_inst64_busy", 0);
    measure(1, hi, bsy);
    check_next(hi);
    check_next(bsy);
    $display("ch1 instant 64: high=%0d busy=%0d", hi, bsy);

    // Full-scale and zero levels
    do_write(2'd3, 8'd255, 1'b1, 1'b0);
    expect_val("ch3_inst255_high", 255);
    measure(3, hi, bsy);
    check_next(hi);
    $display("ch3 instant 255: high=%0d", hi);

    do_write(2'd3, 8'd0, 1'b1, 1'b0);
    expect_val("ch3_inst0_high", 0);
    measure(3, hi, bsy);
    check_next(hi);
    $display("ch3 instant 0: high=%0d", hi);

    // Fade 0 -> 10, write placed on a tick cycle so it is not stepped
    wait_tick_cycle(found);
    expect_val("ch0_align_found", 1);
    check_next(found);
    do_write(2'd0, 8'd10, 1'b0, 1'b0);
    expect_val("ch0_fade10_busy_cycles", 10 * FADE_DIV);
    expect_val("ch0_fade10_busy_after", 0);
    dur = 0;
    while (busy[0] && dur < 20 * FADE_DIV) begin
      dur++;
      step();
    end
    check_next(dur);
    check_next(int'(busy[0]));
    $display("ch0 fade 10: busy_cycles=%0d", dur);
    expect_val("ch0_fade10_high", 10);
    expect_val("ch0_fade10_busy_settled", 0);
    measure(0, hi, bsy);
    check_next(hi);
    check_next(bsy);
    $display("ch0 fade 10 settled: high=%0d busy=%0d", hi, bsy);

    // Fade ch2 up, reverse at level 100 with the write on a tick cycle
    do_write(2'd2, 8'd255, 1'b0, 1'b0);
    found = 0;
    for (int i = 0; i < 120 * FADE_DIV; i++) begin
      if (cur2_m == 100) begin
        found = 1;
        break;
      end
      step();
    end
    if (found == 1) wait_tick_cycle(found);
    expect_val("ch2_reached100_on_tick", 1);
    check_next(found);
    do_write(2'd2, 8'd50, 1'b0, 1'b0);
    expect_val("ch2_reverse_busy_cycles", 50 * FADE_DIV);
    dur = 0;
    while (busy[2] && dur < 60 * FADE_DIV) begin
      dur++;
      step();
    end
    check_next(dur);
    $display("ch2 reverse 100->50: busy_cycles=%0d", dur);
    expect_val("ch2_rev50_high", 50);
    measure(2, hi, bsy);
    check_next(hi);
    $display("ch2 settled: high=%0d", hi);

    // Out-of-range channel on the 3-channel copy
    do_write(2'd3, 8'd200, 1'b1, 1'b1);
    do_write(2'd3, 8'd100, 1'b0, 1'b1);
    expect_val("oor_led_nonzero_cycles", 0);
    expect_val("oor_busy_nonzero_cycles", 0);
    nz_led3 = 0; nz_busy3 = 0;
    for (int i = 0; i < 600; i++) begin
      if (led3 != 3'b000) nz_led3++;
      if (busy3 != 3'b000) nz_busy3++;
      step();
    end
    check_next(nz_led3);
    check_next(nz_busy3);
    $display("out-of-range write: led_nz=%0d busy_nz=%0d", nz_led3, nz_busy3);

    // Asynchronous reset in the middle of a fade
    do_write(2'd0, 8'd200, 1'b0, 1'b0);
    repeat (40) step();
    found = 0;
    for (int i = 0; i < 300; i++) begin
      if (led != 4'b0000) begin
        found = 1;
        break;
      end
      step();
    end
    expect_val("pre_reset_busy0", 1);
    expect_val("pre_reset_led_active", 1);
    check_next(int'(busy[0]));
    check_next(found);
    #3;
    rst_n = 1'b0;
    #1;
    expect_val("async_reset_led", 0);
    expect_val("async_reset_busy", 0);
    expect_val("async_reset_ready", 0);
    check_next(int'(led));
    check_next(int'(busy));
    check_next(int'(wr_ready));
    $display("async reset: led=%b busy=%b ready=%b", led, busy, wr_ready);
    repeat (3) step();
    rst_n = 1'b1;
    idle_check("idle2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
